// File: rtl/nco_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// nco_sweep_ctrl
//
// Steps an NCO through a linear frequency sweep. A sweep is a series of
// nsteps phase increments (start_inc, start_inc+step, ...), each held for
// dwell_eff clock-enabled samples. After the last step the NCO keeps running
// for LAT more cycles (FLUSH) so the samples still inside its pipeline come
// out. A LAT-deep shift register follows the RUN samples through the NCO
// latency, so sample_valid marks exactly the output samples that belong to
// this sweep.
//
// Parameters
//   APR     NCO phase-increment width
//   CNTW    step-count / step-index width
//   DWELLW  dwell-count width
//   LAT     NCO pipeline latency in clken cycles (must be >= 1)
//
// Ports
//   clk            single clock, all state on the rising edge
//   reset_n        asynchronous active-low reset
//   start          one-cycle sweep request, accepted only when idle
//   abort          cancel the sweep in progress (wins over start)
//   cfg_start_inc  first phase increment
//   cfg_step       two's-complement increment delta per step
//   cfg_nsteps     number of frequency steps (0 = immediate done)
//   cfg_dwell      samples per step (0 behaves as 1)
//   nco_clken      NCO clock enable, high in RUN and FLUSH
//   nco_phi_inc    NCO phase increment
//   nco_out_valid  out_valid from the NCO
//   sample_valid   current NCO output sample belongs to this sweep
//   step_idx       current step index
//   busy           state is not IDLE (registered)
//   done           one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module nco_sweep_ctrl #(
    parameter int APR    = 32,
    parameter int CNTW   = 16,
    parameter int DWELLW = 8,
    parameter int LAT    = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [APR-1:0]  cfg_start_inc,
    input  logic [APR-1:0]  cfg_step,
    input  logic [CNTW-1:0] cfg_nsteps,
    input  logic [DWELLW-1:0] cfg_dwell,
    output logic            nco_clken,
    output logic [APR-1:0]  nco_phi_inc,
    input  logic            nco_out_valid,
    output logic            sample_valid,
    output logic [CNTW-1:0] step_idx,
    output logic            busy,
    output logic            done
);

    // The FLUSH counter only needs to reach LAT-1.
    localparam int FLW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [FLW-1:0] FLUSH_LAST = FLW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [APR-1:0]    step_reg;
    logic [CNTW-1:0]   last_step;
    logic [DWELLW-1:0] last_dwell;
    logic [DWELLW-1:0] dwell_cnt;
    logic [FLW-1:0]    flush_cnt;
    logic [LAT-1:0]    valid_sr;

    // The NCO output is ours only when the tag that entered the pipeline
    // LAT clken cycles ago came from RUN, the NCO says its output is valid,
    // and the NCO is actually being clocked this cycle.
    assign sample_valid = valid_sr[LAT-1] & nco_out_valid & nco_clken;

    // Single state machine. The configuration is captured at start so that
    // cfg_* may change freely during a sweep. nco_clken and busy are
    // registered alongside the state and always equal (state != IDLE).
    // Abort is checked before anything else so it beats start and also
    // suppresses a done that would otherwise fire on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            step_reg    <= '0;
            last_step   <= '0;
            last_dwell  <= '0;
            dwell_cnt   <= '0;
            flush_cnt   <= '0;
            valid_sr    <= '0;
            nco_clken   <= 1'b0;
            nco_phi_inc <= '0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                nco_clken <= 1'b0;
                busy      <= 1'b0;
                dwell_cnt <= '0;
                flush_cnt <= '0;
                valid_sr  <= '0;
            end else begin
                // Tag pipeline mirrors the NCO pipeline: it advances only on
                // clken cycles and records whether the sample entering the
                // NCO was a RUN sample.
                if (nco_clken) begin
                    for (int i = LAT - 1; i > 0; i--) begin
                        valid_sr[i] <= valid_sr[i-1];
                    end
                    valid_sr[0] <= (state == RUN);
                end

                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_nsteps != '0) begin
                                step_reg    <= cfg_step;
                                last_step   <= cfg_nsteps - CNTW'(1);
                                last_dwell  <= (cfg_dwell == '0) ? '0
                                                                 : cfg_dwell - DWELLW'(1);
                                nco_phi_inc <= cfg_start_inc;
                                step_idx    <= '0;
                                dwell_cnt   <= '0;
                                flush_cnt   <= '0;
                                state       <= RUN;
                                nco_clken   <= 1'b1;
                                busy        <= 1'b1;
                            end else begin
                                // Empty sweep: report completion straight away.
                                done <= 1'b1;
                            end
                        end
                    end

                    RUN: begin
                        if (dwell_cnt == last_dwell) begin
                            dwell_cnt <= '0;
                            if (step_idx == last_step) begin
                                // Last step has dwelt long enough; hold the
                                // increment and drain the NCO pipeline.
                                state     <= FLUSH;
                                flush_cnt <= '0;
                            end else begin
                                // Modulo-2^APR add; wrap-around is intended.
                                step_idx    <= step_idx + CNTW'(1);
                                nco_phi_inc <= nco_phi_inc + step_reg;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DWELLW'(1);
                        end
                    end

                    FLUSH: begin
                        if (flush_cnt == FLUSH_LAST) begin
                            state     <= IDLE;
                            nco_clken <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            flush_cnt <= flush_cnt + FLW'(1);
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        nco_clken <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter APR, default 32: NCO phase-increment width.
REQ-002 SHALL have parameter CNTW, default 16: step-count and step-index width.
REQ-003 SHALL have parameter DWELLW, default 8: dwell-count width.
REQ-004 SHALL have parameter LAT, default 10: NCO pipeline latency in clken cycles, minimum 1.
REQ-005 SHALL have port clk, in, 1: single clock; all state on rising edge.
REQ-006 SHALL have port reset_n, in, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, in, 1: one-cycle sweep request.
REQ-008 SHALL have port abort, in, 1: cancel the sweep in progress.
REQ-009 SHALL have port cfg_start_inc, in, APR: first phase increment.
REQ-010 SHALL have port cfg_step, in, APR: two's-complement increment delta per step.
REQ-011 SHALL have port cfg_nsteps, in, CNTW: number of frequency steps.
REQ-012 SHALL have port cfg_dwell, in, DWELLW: samples per step; 0 means 1.
REQ-013 SHALL have port nco_clken, out, 1: drives the NCO clken.
REQ-014 SHALL have port nco_phi_inc, out, APR: drives the NCO phi_inc_i.
REQ-015 SHALL have port nco_out_valid, in, 1: the NCO out_valid.
REQ-016 SHALL have port sample_valid, out, 1: the NCO output belongs to this sweep.
REQ-017 SHALL have port step_idx, out, CNTW: current step index.
REQ-018 SHALL have port busy, out, 1: state is not IDLE.
REQ-019 SHALL have port done, out, 1: one-cycle pulse at normal completion.

Function
REQ-020 SHALL implement a state machine with states IDLE, RUN and FLUSH.
REQ-021 In IDLE, start=1 with cfg_nsteps>0 SHALL latch all cfg_* inputs, load nco_phi_inc=cfg_start_inc, clear step_idx and the dwell counter, and enter RUN on the next cycle.
REQ-022 In IDLE, start=1 with cfg_nsteps=0 SHALL pulse done on the next cycle and remain in IDLE.
REQ-023 nco_clken SHALL be 1 in RUN and FLUSH, and 0 in IDLE.
REQ-024 In RUN, the dwell counter SHALL increment every cycle.
REQ-025 In RUN, when the dwell counter equals dwell_eff-1, the counter SHALL clear.
REQ-026 At that dwell wrap, if step_idx=nsteps-1 the block SHALL enter FLUSH; otherwise it SHALL increment step_idx and add cfg_step to nco_phi_inc.
REQ-027 The nco_phi_inc addition SHALL be modulo 2^APR; wrap-around is not flagged.
REQ-028 RUN SHALL last exactly nsteps*dwell_eff cycles.
REQ-029 FLUSH SHALL last exactly LAT cycles, with nco_phi_inc and step_idx held.
REQ-030 On leaving FLUSH, the block SHALL return to IDLE and pulse done for exactly 1 cycle.
REQ-031 The block SHALL contain an LAT-deep shift register: input is 1 in RUN and 0 otherwise; it shifts only when nco_clken=1.
REQ-032 sample_valid SHALL equal (shift register tail) AND nco_out_valid AND nco_clken.
REQ-033 sample_valid SHALL therefore be asserted for exactly nsteps*dwell_eff cycles per completed sweep, the first LAT cycles after RUN entry.
REQ-034 start SHALL be ignored while busy=1.
REQ-035 cfg_* changes while busy=1 SHALL have no effect.
REQ-036 abort=1 in any state SHALL force IDLE on the next cycle, with nco_clken=0, the shift register cleared and no done pulse.
REQ-037 abort SHALL have priority over start in the same cycle.
REQ-038 busy SHALL be registered and equal (state is not IDLE).

Reset
REQ-039 While reset_n=0, the block SHALL be in IDLE with nco_clken=0, nco_phi_inc=0, step_idx=0, sample_valid=0, busy=0, done=0, dwell counter=0 and shift register all 0.
REQ-040 Reset assertion mid-sweep SHALL take effect immediately, without waiting for a clock edge.
REQ-041 After reset_n deasserts, the first start SHALL begin a sweep normally.

Verification
REQ-042 Basic sweep: start_inc=0x01000000, step=0x00100000, nsteps=4, dwell=3, LAT=10, start at cycle 0, nco_out_valid tied 1 -> RUN in cycles 1-12; nco_phi_inc=0x01000000, 0x01100000, 0x01200000, 0x01300000 for 3 cycles each; sample_valid in cycles 11-22; FLUSH in cycles 13-22; done=1 in cycle 23.
REQ-043 Wrap and negative step: start_inc=0xFFFFFF00, step=0x200, nsteps=2 -> second value 0x00000100; then step=0xFFF00000 from 0x00100000 -> second value 0x00000000.
REQ-044 Degenerate configs: dwell=0 behaves as dwell=1 (nsteps=5 gives 5 RUN cycles); nsteps=0 gives a done pulse 1 cycle after start, with busy and nco_clken never set.
REQ-045 Abort: abort at RUN cycle 5 -> IDLE next cycle, nco_clken=0, no done, no further sample_valid; a new start then produces the full REQ-042 sequence.
REQ-046 Conflicts: start pulsed while busy is ignored; start and abort in the same cycle from IDLE leave the block in IDLE; reset_n pulsed low mid-FLUSH clears all outputs asynchronously.
